// File: rtl/frame_pkg.sv
// Framing constants and receive FSM encoding shared by frame_rx and the upstream serialiser.
package frame_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Running even-parity accumulator step
  function automatic logic par_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/rx_bit_cnt.sv
// Payload bit index for frame_rx: synchronous clear, count enable, terminal count at WIDTH-1.
module rx_bit_cnt
  import frame_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_idx,
  output logic          o_tc
);

  logic [CW-1:0] r_idx;
  logic          w_tc;

  assign w_tc  = (r_idx == CW'(WIDTH - 1));
  assign o_idx = r_idx;
  assign o_tc  = w_tc;

  // Index register; wraps to zero after the last payload bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= w_tc ? '0 : r_idx + CW'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

endmodule

// File: rtl/frame_rx.sv
// Serial frame receiver: start, WIDTH payload bits LSB first, optional even parity, stop.
// Completed words sit in a single output register with a valid/ready handshake.
module frame_rx
  import frame_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             err,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic [WIDTH-1:0] r_o;
  logic             r_valid;
  logic             r_err;
  logic             r_ovf;
  logic [CW-1:0]    w_idx;
  logic             w_tc;
  logic             w_good;
  logic             w_bad;

  rx_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == ST_IDLE),
    .i_en  (r_state == ST_DATA),
    .o_idx (w_idx),
    .o_tc  (w_tc)
  );

  // A bad stop bit of 0 returns to IDLE and is never reused as a start bit
  assign w_good = (r_state == ST_STOP) && (data == STOP_BIT) && (!r_par || (PARITY_EN == 0));
  assign w_bad  = (r_state == ST_STOP) && !w_good;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (data == START_BIT) begin
          w_next = ST_DATA;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!w_tc) begin
          w_next = ST_DATA;
        end else if (PARITY_EN != 0) begin
          w_next = ST_PARITY;
        end else begin
          w_next = ST_STOP;
        end
      end
      ST_PARITY: w_next = ST_STOP;
      ST_STOP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State register and payload/parity accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: r_par <= 1'b0;
        ST_DATA: begin
          r_shift[w_idx] <= data;
          r_par          <= par_step(r_par, data);
        end
        ST_PARITY: r_par <= par_step(r_par, data);
        default:   r_par <= r_par;
      endcase
    end
  end

  // Output register: a completing frame wins over a same-cycle handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_err <= w_bad;
      r_ovf <= w_good && r_valid && !o_ready;
      if (w_good && (!r_valid || o_ready)) begin
        r_o     <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && o_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign o       = r_o;
  assign o_valid = r_valid;
  assign err     = r_err;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_frame_rx.sv
// Directed and randomized frame stimulus for frame_rx against a frame-level reference model.
module tb_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       data;
  logic       o_ready;
  logic [3:0] o;
  logic       o_valid;
  logic       err;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_o;
  logic       m_valid;

  frame_rx #(.WIDTH(4), .PARITY_EN(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .err     (err),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic e_err, input logic e_ovf);
    chk("o",       {28'd0, o},       {28'd0, m_o});
    chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("err",     {31'd0, err},     {31'd0, e_err});
    chk("ovf",     {31'd0, ovf},     {31'd0, e_ovf});
    chk("err_ovf_excl", {31'd0, err & ovf}, 32'd0);
  endtask

  // One line bit per clock; is_end marks the stop bit of a frame whose verdict is good
  task automatic step(input logic d, input logic rdy, input bit is_end,
                      input logic [3:0] word, input bit good);
    logic e_err;
    logic e_ovf;
    data    = d;
    o_ready = rdy;
    @(posedge clk);
    e_err = is_end && !good;
    e_ovf = is_end && good && m_valid && !rdy;
    if (is_end && good && (!m_valid || rdy)) begin
      m_o     = word;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs(e_err, e_ovf);
  endtask

  // mode 0: ready low, 1: ready high, 2: random, 3: high only on the stop bit
  function automatic logic pick_rdy(input int mode, input bit last);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      3:       return last;
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_frame(input logic [3:0] pl, input bit bad_par, input logic stp, input int mode);
    logic par;
    bit   good;
    par  = (^pl) ^ bad_par;
    good = (stp == 1'b1) && !bad_par;
    step(1'b0, pick_rdy(mode, 1'b0), 1'b0, pl, good);
    for (int i = 0; i < 4; i++) step(pl[i], pick_rdy(mode, 1'b0), 1'b0, pl, good);
    step(par, pick_rdy(mode, 1'b0), 1'b0, pl, good);
    step(stp, pick_rdy(mode, 1'b1), 1'b1, pl, good);
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) step(1'b1, pick_rdy(mode, 1'b0), 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    data    = 1'b1;
    o_ready = 1'b0;
    m_o     = 4'd0;
    m_valid = 1'b0;
    #1;
    check_outputs(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3, 1);

    // Good frame, payload 1011
    send_frame(4'b1011, 1'b0, 1'b1, 1);
    idle(3, 1);
    // Parity error: 0,1,1,0,1,0,1
    send_frame(4'b1011, 1'b1, 1'b1, 1);
    idle(3, 1);
    // Stop error: all zeros
    send_frame(4'b0000, 1'b0, 1'b0, 1);
    idle(4, 1);
    // Overflow then drain
    send_frame(4'b0001, 1'b0, 1'b1, 0);
    send_frame(4'b1000, 1'b0, 1'b1, 0);
    idle(2, 0);
    idle(3, 1);
    // Second frame completes on the handshake cycle
    send_frame(4'b0101, 1'b0, 1'b1, 0);
    send_frame(4'b1110, 1'b0, 1'b1, 3);
    idle(3, 1);

    // Reset mid-frame with a word held in the output register
    send_frame(4'b1001, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst     = 1'b1;
    m_o     = 4'd0;
    m_valid = 1'b0;
    #1;
    check_outputs(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 1);
    send_frame(4'b0110, 1'b0, 1'b1, 1);
    idle(2, 1);

    // Randomized frames, faults and gaps
    for (int n = 0; n < 60; n++) begin
      send_frame(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1,
                 int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)), 2);
    end
    idle(3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_rx.md
FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 Parameter WIDTH, default 4: payload bits per frame.
REQ-002 Parameter PARITY_EN, default 1: 1 = even-parity bit present after payload, 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 data  input  1  serial line from upstream system stage, synchronous to clk, one bit per cycle, idle level 1.
REQ-006 o  output  WIDTH  received payload word, valid while o_valid=1.
REQ-007 o_valid  output  1  payload held in output register.
REQ-008 o_ready  input  1  consumer accepts o when o_valid=1 and o_ready=1 on a rising edge.
REQ-009 err  output  1  one-cycle pulse: frame discarded (parity or stop error).
REQ-010 ovf  output  1  one-cycle pulse: good frame dropped because output register still full.

Function
REQ-011 Frame on data SHALL be: start bit 0, WIDTH payload bits LSB first, parity bit if PARITY_EN, stop bit 1; one bit sampled per clk cycle, no oversampling.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: data=0 -> DATA with bit index cleared; data=1 -> stay IDLE.
REQ-014 DATA: shift sampled bit into payload position index; after bit WIDTH-1 -> PARITY if PARITY_EN else STOP.
REQ-015 PARITY: frame is good only if XOR of payload and parity bit is 0; always -> STOP, parity result retained.
REQ-016 STOP: data=1 and parity good -> frame complete; otherwise err pulses next cycle and frame discarded; always -> IDLE.
REQ-017 A 0 sampled as a bad stop bit SHALL NOT be taken as a new start bit; the next cycle is evaluated from IDLE.
REQ-018 Latency: o_valid SHALL rise on the cycle after the stop bit is sampled; o updates in the same cycle.
REQ-019 o and o_valid SHALL hold unchanged until handshake; handshake clears o_valid next cycle unless a new frame loads that same cycle.
REQ-020 Frame completion while o_valid=1 and o_ready=0: new frame dropped, ovf pulses, o keeps old word.
REQ-021 Frame completion on the same cycle as handshake: new word loaded, o_valid stays 1, no ovf.
REQ-022 err and ovf SHALL never be 1 together; each is high exactly one cycle per event.
REQ-023 Back-to-back frames (start bit immediately after stop bit) SHALL be received without gap cycles.
REQ-024 Receive FSM SHALL run independently of o_ready (no backpressure on the line).

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, bit index 0, o=0, o_valid=0, err=0, ovf=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first data=0 after release starts a new frame.

Structure
REQ-027 Shared package frame_pkg SHALL hold the FSM state encoding, LINE_IDLE=1, START_BIT=0, STOP_BIT=1 and default WIDTH.
REQ-028 One sub-module rx_bit_cnt (clear, enable, terminal-count at WIDTH-1, async reset) SHALL provide the bit index.
REQ-029 Transmit-side package constants SHALL be shared with the upstream serialiser so framing matches on both sides.

Verification
REQ-030 Good frame: data 0,1,1,0,1,1,1 (payload 4'b1011, parity 1, stop 1), o_ready=1 -> o=4'b1011, o_valid=1 for one cycle after stop, err=0.
REQ-031 Parity error: data 0,1,1,0,1,0,1 -> err one pulse, o_valid stays 0.
REQ-032 Stop error: data 0,0,0,0,0,0,0 -> err one pulse after seventh bit, next cycle IDLE, no second frame started.
REQ-033 Overflow: two back-to-back good frames 4'b0001 then 4'b1000 with o_ready=0 -> o=4'b0001 retained, ovf one pulse; then o_ready=1 -> o_valid drops next cycle.
REQ-034 Simultaneous: o_ready=1 on the cycle the second of two good frames completes -> o=second word, o_valid continuous, ovf=0.
REQ-035 Reset mid-frame: rst pulsed after third payload bit -> all outputs 0 at once; following complete frame 4'b0110 received correctly.
